// File: rtl/sign_extend_26x32_pkg.sv
// sign_extend_26x32_pkg: shared widths and extension-mode encoding
package sign_extend_26x32_pkg;
   localparam int IN_W_DEF   = 26;
   localparam int OUT_W_DEF  = 32;
   localparam int JT_PC_BITS = 4;
   typedef enum logic {EXT_SIGN = 1'b0, EXT_ZERO = 1'b1} ext_mode_e;
endpackage

// File: rtl/sign_extend_26x32_sext_core.sv
// sign_extend_26x32_sext_core: combinational sign/zero extension of a narrow field
module sign_extend_26x32_sext_core
   import sign_extend_26x32_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [IN_W-1:0]  in_i,
   input  ext_mode_e        mode_i,
   output logic [OUT_W-1:0] out_o
);
   logic fill;
   // fill bit is the field's MSB in sign mode and zero in zero mode
   always_comb begin
      fill  = (mode_i == EXT_SIGN) ? in_i[IN_W-1] : 1'b0;
      out_o = {{(OUT_W-IN_W){fill}}, in_i};
   end
endmodule

// File: rtl/sign_extend_26x32.sv
// sign_extend_26x32: 26->32 bit extension with optional registered copy;
// define SIGNEXT_JUMP_TARGET_EN to add the J-type jump-target outputs
module sign_extend_26x32
   import sign_extend_26x32_pkg::*;
#(
   parameter int IN_W    = IN_W_DEF,
   parameter int OUT_W   = OUT_W_DEF,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  Input_26,
   input  logic             zero_ext,
   input  logic             in_valid,
`ifdef SIGNEXT_JUMP_TARGET_EN
   input  logic [JT_PC_BITS-1:0] pc_hi,
   output logic [31:0]      jump_target,
   output logic [31:0]      jump_target_q,
`endif
   output logic [OUT_W-1:0] Output_32,
   output logic [OUT_W-1:0] ext_q,
   output logic             ext_valid_q,
   output logic             neg_q
);
   logic sign_flag;
   sign_extend_26x32_sext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .in_i   (Input_26),
      .mode_i (ext_mode_e'(zero_ext)),
      .out_o  (Output_32)
   );
   assign sign_flag = Input_26[IN_W-1] & ~zero_ext;
`ifdef SIGNEXT_JUMP_TARGET_EN
   assign jump_target = {pc_hi, Input_26, 2'b00};
`endif
   if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] ext_d;
      logic             neg_d;
      // a new valid input overwrites the held result; otherwise hold it
      always_comb begin
         ext_d = in_valid ? Output_32 : ext_q;
         neg_d = in_valid ? sign_flag : neg_q;
      end
      // reset wins over in_valid; valid flag lasts one cycle per input
      always_ff @(posedge clk) begin
         if (reset) begin
            ext_q       <= '0;
            neg_q       <= 1'b0;
            ext_valid_q <= 1'b0;
         end else begin
            ext_q       <= ext_d;
            neg_q       <= neg_d;
            ext_valid_q <= in_valid;
         end
      end
`ifdef SIGNEXT_JUMP_TARGET_EN
      logic [31:0] jt_d;
      // jump target follows the same capture rules as ext_q
      always_comb jt_d = in_valid ? jump_target : jump_target_q;
      // registered jump target, cleared by reset
      always_ff @(posedge clk) jump_target_q <= reset ? 32'd0 : jt_d;
`endif
   end else begin : g_noreg
      assign ext_q       = '0;
      assign neg_q       = 1'b0;
      assign ext_valid_q = 1'b0;
`ifdef SIGNEXT_JUMP_TARGET_EN
      assign jump_target_q = 32'd0;
`endif
   end
endmodule

// File: tb/tb_sign_extend_26x32.sv
// tb_sign_extend_26x32: randomized self-checking bench against an arithmetic model
module tb_sign_extend_26x32;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [25:0] Input_26 = '0;
   logic        zero_ext = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] Output_32, ext_q;
   logic        ext_valid_q, neg_q;
`ifdef SIGNEXT_JUMP_TARGET_EN
   logic [3:0]  pc_hi = '0;
   logic [31:0] jump_target, jump_target_q;
   logic [31:0] m_jt = '0;
`endif
   logic [31:0] m_ext = '0;
   logic        m_v = 1'b0, m_neg = 1'b0;
   int n_chk = 0, n_pass = 0;

   sign_extend_26x32 dut (
      .clk         (clk),
      .reset       (reset),
      .Input_26    (Input_26),
      .zero_ext    (zero_ext),
      .in_valid    (in_valid),
`ifdef SIGNEXT_JUMP_TARGET_EN
      .pc_hi        (pc_hi),
      .jump_target  (jump_target),
      .jump_target_q(jump_target_q),
`endif
      .Output_32   (Output_32),
      .ext_q       (ext_q),
      .ext_valid_q (ext_valid_q),
      .neg_q       (neg_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
   endtask

   function automatic logic [31:0] ref_ext(input int unsigned x, input bit z);
      longint v;
      v = longint'(x);
      if (!z && x >= 32'h200_0000) v = v - 64'h400_0000 + 64'h1_0000_0000;
      return v[31:0];
   endfunction

   task automatic step(input int unsigned x, input bit z, input bit v, input bit r, input logic [3:0] pc);
      logic [31:0] e;
      Input_26 = x[25:0];
      zero_ext = z;
      in_valid = v;
      reset    = r;
`ifdef SIGNEXT_JUMP_TARGET_EN
      pc_hi = pc;
`endif
      #1;
      e = ref_ext(x, z);
      check("comb", Output_32, e);
`ifdef SIGNEXT_JUMP_TARGET_EN
      check("jt_comb", jump_target, pc * 32'h1000_0000 + x * 4);
`endif
      if (r) begin
         m_ext = 0; m_v = 0; m_neg = 0;
`ifdef SIGNEXT_JUMP_TARGET_EN
         m_jt = 0;
`endif
      end else if (v) begin
         m_ext = e; m_v = 1; m_neg = (!z && x >= 32'h200_0000);
`ifdef SIGNEXT_JUMP_TARGET_EN
         m_jt = pc * 32'h1000_0000 + x * 4;
`endif
      end else m_v = 0;
      @(posedge clk);
      #1;
      check("ext_q", ext_q, m_ext);
      check("ext_valid_q", {31'd0, ext_valid_q}, {31'd0, m_v});
      check("neg_q", {31'd0, neg_q}, {31'd0, m_neg});
`ifdef SIGNEXT_JUMP_TARGET_EN
      check("jt_q", jump_target_q, m_jt);
`endif
   endtask

   initial begin
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      check("boundary_0_sign", ref_ext(0, 0), Output_32);
      step(2, 0, 1, 0, 0);
      step(6, 0, 1, 0, 0);
      step(32'h3FF_FFFE, 0, 1, 0, 0);
      check("neg_fffe", Output_32, 32'hFFFF_FFFE);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(32'h3FF_FFFE, 1, 1, 0, 0);
      check("zext_fffe", Output_32, 32'h03FF_FFFE);
      step(32'h200_0000, 1, 1, 0, 0);
      check("zext_min", Output_32, 32'h0200_0000);
      step(32'h200_0000, 0, 1, 0, 0);
      check("sext_min", Output_32, 32'hFE00_0000);
      step(32'h1FF_FFFF, 0, 1, 0, 0);
      check("max_pos", Output_32, 32'h01FF_FFFF);
      step(32'h3FF_FFFF, 0, 1, 0, 0);
      check("all_ones", Output_32, 32'hFFFF_FFFF);
      step(5, 0, 0, 0, 0);
      step(7, 1, 0, 0, 0);
      step(9, 0, 0, 0, 0);
      step(32'h3FF_0000, 0, 1, 0, 0);
      step(32'h3FF_0000, 0, 1, 1, 0);
      step(32'h10, 0, 1, 0, 4'hA);
`ifdef SIGNEXT_JUMP_TARGET_EN
      check("jt_a", jump_target_q, 32'hA000_0040);
`endif
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 32'h3FF_FFFF), 1'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0), 4'($urandom));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
